// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB slave fronting a word-organised single-port SRAM.
// Every OKAY transfer takes WAIT_STATES stall cycles before completing.
// Illegal accesses get the two-cycle ERROR response and never touch memory.
// A read accepted on the same edge as a write commit picks up the new bytes
// through a small forwarding path, so the SRAM itself can stay read-first.
module ahb_sram_slave #(
  parameter int MEM_AW      = 10,
  parameter int REGION_BITS = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADY_OUT,
  output logic [1:0]  HRESP,
  output logic [15:0] HSPLIT,
  output logic [31:0] HRDATA
);

  localparam int MEM_WORDS = 1 << MEM_AW;
  // Wait-state cycles are counted down to zero, so load one less than the total.
  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  // Address bits inside the decoded window that lie beyond the memory size.
  localparam logic [31:0] RANGE_MASK =
    ((32'd1 << REGION_BITS) - 32'd1) & ~((32'd1 << (MEM_AW + 2)) - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [2:0]        r_waitCnt;
  logic              r_write;
  logic              r_read;
  logic [MEM_AW-1:0] r_wordAddr;
  logic [3:0]        r_byteEn;
  logic [31:0]       r_memRd;
  logic [3:0]        r_fwdEn;
  logic [31:0]       r_fwdData;
  logic [31:0]       r_mem [MEM_WORDS];

  logic              w_accept;
  logic              w_legal;
  logic              w_commit;
  logic              w_unused;
  logic [MEM_AW-1:0] w_addrWord;
  logic [3:0]        w_byteEn;
  logic [31:0]       w_readWord;

  // Burst type and the SEQ/NONSEQ distinction do not change how a beat is handled.
  assign w_unused = ^{HBURST, HTRANS[0]};

  // HREADY_OUT low means our own data phase is still stalling the bus.
  // Gating on it keeps control held by the master during our waits from being re-accepted.
  assign w_accept   = HSEL & HREADY & HTRANS[1] & HREADY_OUT;
  assign w_addrWord = HADDR[MEM_AW+1:2];
  assign w_commit   = (r_state == S_DONE) & r_write & ~HRESET;

  // Decode byte enables for the offered address phase and decide if it is legal.
  always_comb begin
    w_byteEn = 4'b0000;
    w_legal  = 1'b1;
    case (HSIZE)
      3'd0: w_byteEn = 4'b0001 << HADDR[1:0];
      3'd1: begin
        w_byteEn = HADDR[1] ? 4'b1100 : 4'b0011;
        if (HADDR[0]) w_legal = 1'b0;
      end
      3'd2: begin
        w_byteEn = 4'b1111;
        if (HADDR[1:0] != 2'b00) w_legal = 1'b0;
      end
      default: w_legal = 1'b0;
    endcase
    if ((HADDR & RANGE_MASK) != 32'd0) w_legal = 1'b0;
  end

  // Next-state logic for the data-phase sequencer.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_WAIT: begin
        if (r_waitCnt == 3'd0) w_stateNext = S_DONE;
      end
      S_ERR1: w_stateNext = S_ERR2;
      default: begin
        if (w_accept) begin
          if (!w_legal)              w_stateNext = S_ERR1;
          else if (WAIT_STATES == 0) w_stateNext = S_DONE;
          else                       w_stateNext = S_WAIT;
        end else begin
          w_stateNext = S_IDLE;
        end
      end
    endcase
  end

  // State register and the data-phase context latched at address-phase accept.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state    <= S_IDLE;
      r_waitCnt  <= 3'd0;
      r_write    <= 1'b0;
      r_read     <= 1'b0;
      r_wordAddr <= '0;
      r_byteEn   <= 4'b0000;
      r_fwdEn    <= 4'b0000;
      r_fwdData  <= 32'd0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == S_WAIT) r_waitCnt <= r_waitCnt - 3'd1;
      if (w_accept) begin
        r_waitCnt  <= WAIT_LOAD;
        r_write    <= HWRITE & w_legal;
        r_read     <= ~HWRITE & w_legal;
        r_wordAddr <= w_addrWord;
        r_byteEn   <= w_byteEn;
        r_fwdEn    <= (w_commit && (r_wordAddr == w_addrWord)) ? r_byteEn : 4'b0000;
        r_fwdData  <= HWDATA;
      end
    end
  end

  // SRAM array: byte-masked write at the end of DONE, read-first synchronous read at accept.
  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (r_byteEn[i]) r_mem[r_wordAddr][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
    if (w_accept) r_memRd <= r_mem[w_addrWord];
  end

  // Merge forwarded write bytes over the stale word the SRAM returned.
  always_comb begin
    w_readWord = r_memRd;
    for (int i = 0; i < 4; i++) begin
      if (r_fwdEn[i]) w_readWord[8*i +: 8] = r_fwdData[8*i +: 8];
    end
  end

  assign HREADY_OUT = !((r_state == S_WAIT) || (r_state == S_ERR1));
  assign HRESP      = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? 2'b01 : 2'b00;
  assign HSPLIT     = 16'd0;
  assign HRDATA     = (r_read && ((r_state == S_WAIT) || (r_state == S_DONE))) ? w_readWord : 32'd0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: two slaves (one wait state and zero wait states) driven in turn
// by a pipelined master model. The expected responses are kept on a scoreboard.
// The scoreboard is checked against a plain per-word memory model.
module tb_ahb_sram_slave;

  localparam int MEM_AW      = 10;
  localparam int REGION_BITS = 16;
  localparam int WS0         = 1;
  localparam int WS1         = 0;
  localparam int NWORDS      = 1 << MEM_AW;

  typedef struct {
    bit          write;
    bit          legal;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          hasFix;
    logic [31:0] fix;
  } txn_t;

  logic HCLK   = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  logic        mSel, mWrite, stall;
  logic [1:0]  mTrans;
  logic [2:0]  mSize, mBurst;
  logic [31:0] mAddr, mWdata;
  int          cur;

  logic        sel0, sel1, busReady0, busReady1, ro0, ro1, busReadyCur, rdyOut;
  logic [1:0]  resp0, resp1, respOut;
  logic [15:0] split0, split1, splitOut;
  logic [31:0] rdata0, rdata1, rdataOut;

  txn_t        expQ[$];
  logic [31:0] mdl [2][NWORDS];
  int          checks = 0;
  int          errors = 0;
  int          waitCnt = 0;
  txn_t        monT;
  int          monWord, monWaits;
  logic [31:0] monRd;
  logic [1:0]  monResp;
  int          rKind;
  logic [31:0] rAddr;
  logic [2:0]  rSize;
  logic        rWrite, rSel;
  logic [1:0]  rTrans;

  assign sel0        = mSel && (cur == 0);
  assign sel1        = mSel && (cur == 1);
  assign busReady0   = ro0 && !stall;
  assign busReady1   = ro1 && !stall;
  assign busReadyCur = (cur == 0) ? busReady0 : busReady1;
  assign rdyOut      = (cur == 0) ? ro0 : ro1;
  assign respOut     = (cur == 0) ? resp0 : resp1;
  assign splitOut    = (cur == 0) ? split0 : split1;
  assign rdataOut    = (cur == 0) ? rdata0 : rdata1;

  ahb_sram_slave #(.MEM_AW(MEM_AW), .REGION_BITS(REGION_BITS), .WAIT_STATES(WS0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel0), .HTRANS(mTrans), .HWRITE(mWrite),
    .HSIZE(mSize), .HBURST(mBurst), .HADDR(mAddr), .HWDATA(mWdata), .HREADY(busReady0),
    .HREADY_OUT(ro0), .HRESP(resp0), .HSPLIT(split0), .HRDATA(rdata0));

  ahb_sram_slave #(.MEM_AW(MEM_AW), .REGION_BITS(REGION_BITS), .WAIT_STATES(WS1)) dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel1), .HTRANS(mTrans), .HWRITE(mWrite),
    .HSIZE(mSize), .HBURST(mBurst), .HADDR(mAddr), .HWDATA(mWdata), .HREADY(busReady1),
    .HREADY_OUT(ro1), .HRESP(resp1), .HSPLIT(split1), .HRDATA(rdata1));

  function automatic logic [63:0] pack(logic r, logic [1:0] rs, logic [31:0] d, logic [15:0] sp);
    return {13'd0, r, rs, d, sp};
  endfunction

  // An access is legal when its size is byte/half/word, it is naturally aligned,
  // and its offset inside the decoded window lands inside the memory.
  function automatic bit isLegal(logic [31:0] a, logic [2:0] s);
    if (s > 3'd2) return 1'b0;
    if ((a % (32'd1 << s)) != 32'd0) return 1'b0;
    return (a % (32'd1 << REGION_BITS)) < (32'd1 << (MEM_AW + 2));
  endfunction

  function automatic void modelWrite(int d, txn_t t);
    int lane = int'(t.addr[1:0]);
    int nb   = 1 << t.size;
    int w    = int'((t.addr >> 2) % NWORDS);
    for (int b = lane; b < lane + nb; b++) mdl[d][w][8*b +: 8] = t.wdata[8*b +: 8];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d t=%0t: got %h expected %h", name, cur, $time, act, exp);
    end
  endtask

  // Present one address phase and hold it until the bus accepts it.
  // Selected NONSEQ/SEQ beats go onto the scoreboard. HWDATA is then driven for the new data phase.
  task automatic applyStimulus(input logic s, input logic [1:0] tr, input logic w, input logic [2:0] sz,
                               input logic [31:0] a, input logic [31:0] wd,
                               input bit hasFix, input logic [31:0] fix);
    bit   rdy;
    int   n;
    txn_t t;
    n      = 0;
    mSel   = s;
    mTrans = tr;
    mWrite = w;
    mSize  = sz;
    mAddr  = a;
    mBurst = 3'($urandom_range(0, 7));
    do begin
      @(negedge HCLK);
      rdy = busReadyCur;
      @(posedge HCLK);
      #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) begin
      checkOutput("acceptTimeout", 64'(n), 64'(0));
    end else if (s && tr[1]) begin
      t.write  = w;
      t.legal  = isLegal(a, sz);
      t.addr   = a;
      t.size   = sz;
      t.wdata  = wd;
      t.hasFix = hasFix;
      t.fix    = fix;
      expQ.push_back(t);
      mWdata = w ? wd : $urandom;
    end else begin
      mWdata = $urandom;
    end
  endtask

  task automatic doWrite(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    applyStimulus(1'b1, 2'b10, 1'b1, sz, a, wd, 1'b0, 32'h0);
  endtask

  task automatic doRead(input logic [31:0] a, input logic [31:0] fix);
    applyStimulus(1'b1, 2'b10, 1'b0, 3'd2, a, 32'h0, 1'b1, fix);
  endtask

  task automatic flush();
    applyStimulus(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge HCLK);
    #1;
  endtask

  // Monitor: each cycle either there is no data phase, so outputs must be idle OKAY, or
  // the oldest scoreboard entry is in its data phase. Stall cycles are counted against the
  // expected wait count. The completing cycle checks response and data, then retires the entry into the model.
  always @(negedge HCLK) begin
    if (HRESET) begin
      expQ.delete();
      waitCnt = 0;
    end else if (expQ.size() == 0) begin
      checkOutput("idleOut", pack(rdyOut, respOut, rdataOut, splitOut), pack(1'b1, 2'b00, 32'h0, 16'h0));
    end else begin
      monT     = expQ[0];
      monWord  = int'((monT.addr >> 2) % NWORDS);
      monRd    = (monT.legal && !monT.write) ? mdl[cur][monWord] : 32'h0;
      monResp  = monT.legal ? 2'b00 : 2'b01;
      monWaits = monT.legal ? ((cur == 0) ? WS0 : WS1) : 1;
      if (!rdyOut) begin
        waitCnt++;
        if (waitCnt > monWaits) begin
          checkOutput("waitCount", 64'(waitCnt), 64'(monWaits));
          void'(expQ.pop_front());
          waitCnt = 0;
        end else begin
          checkOutput("waitOut", pack(rdyOut, respOut, rdataOut, splitOut), pack(1'b0, monResp, monRd, 16'h0));
        end
      end else begin
        checkOutput("doneWaits", 64'(waitCnt), 64'(monWaits));
        checkOutput("doneOut", pack(rdyOut, respOut, rdataOut, splitOut), pack(1'b1, monResp, monRd, 16'h0));
        if (monT.hasFix) checkOutput("fixedRead", 64'(rdataOut), 64'(monT.fix));
        if (monT.legal && monT.write) modelWrite(cur, monT);
        void'(expQ.pop_front());
        waitCnt = 0;
      end
    end
  end

  // Main sequence: reset, then the same directed and random program for each slave in turn.
  initial begin
    mSel = 1'b0; mTrans = 2'b00; mWrite = 1'b0; mSize = 3'd2; mBurst = 3'd0;
    mAddr = 32'h0; mWdata = 32'h0; stall = 1'b0; cur = 0;

    repeat (2) @(posedge HCLK);
    #1;
    checkOutput("reset0", pack(ro0, resp0, rdata0, split0), pack(1'b1, 2'b00, 32'h0, 16'h0));
    checkOutput("reset1", pack(ro1, resp1, rdata1, split1), pack(1'b1, 2'b00, 32'h0, 16'h0));
    HRESET = 1'b0;

    for (int d = 0; d < 2; d++) begin
      cur = d;
      $display("[TB] exercising slave %0d", d);

      // Fill words 0..63 so every later read has a known model value.
      for (int w = 0; w < 64; w++)
        applyStimulus(1'b1, (w == 0) ? 2'b10 : 2'b11, 1'b1, 3'd2, 32'(w * 4), $urandom, 1'b0, 32'h0);

      // Word write then immediate read of the same word.
      doWrite(32'h10, 3'd2, 32'hDEADBEEF);
      doRead(32'h10, 32'hDEADBEEF);

      // Byte and halfword lane placement.
      doWrite(32'h20, 3'd2, 32'h11223344);
      doWrite(32'h21, 3'd0, 32'h0000AA00);
      doWrite(32'h22, 3'd1, 32'hBBCC0000);
      doRead(32'h20, 32'hBBCCAA44);
      flush();

      // Back-to-back burst; the first read hits the word written just before it.
      for (int k = 0; k < 4; k++)
        applyStimulus(1'b1, (k == 0) ? 2'b10 : 2'b11, 1'b1, 3'd2, 32'h40 + 32'(4 * k), 32'(k + 1), 1'b0, 32'h0);
      applyStimulus(1'b1, 2'b10, 1'b0, 3'd2, 32'h4C, 32'h0, 1'b1, 32'h4);
      for (int k = 0; k < 3; k++)
        applyStimulus(1'b1, 2'b11, 1'b0, 3'd2, 32'h40 + 32'(4 * k), 32'h0, 1'b1, 32'(k + 1));
      flush();

      // Illegal accesses: misaligned word, bad size, out-of-range write.
      doWrite(32'h0, 3'd2, 32'h0BADF00D);
      applyStimulus(1'b1, 2'b10, 1'b0, 3'd2, 32'h02, 32'h0, 1'b0, 32'h0);
      applyStimulus(1'b1, 2'b10, 1'b0, 3'd3, 32'h10, 32'h0, 1'b0, 32'h0);
      doWrite(32'h1000, 3'd2, 32'h55);
      doRead(32'h0, 32'h0BADF00D);
      flush();

      // BUSY, unselected and IDLE beats must not touch memory.
      applyStimulus(1'b1, 2'b01, 1'b1, 3'd2, 32'h10, 32'h99999999, 1'b0, 32'h0);
      applyStimulus(1'b0, 2'b10, 1'b1, 3'd2, 32'h10, 32'h77777777, 1'b0, 32'h0);
      applyStimulus(1'b1, 2'b00, 1'b1, 3'd2, 32'h10, 32'h66666666, 1'b0, 32'h0);
      doRead(32'h10, 32'hDEADBEEF);
      flush();

      // Another slave holds bus HREADY low; our offered write must wait for it.
      stall = 1'b1;
      mSel = 1'b1; mTrans = 2'b10; mWrite = 1'b1; mSize = 3'd2; mAddr = 32'hA0;
      repeat (3) @(posedge HCLK);
      #1;
      stall = 1'b0;
      doWrite(32'hA0, 3'd2, 32'hCAFE0001);
      doRead(32'hA0, 32'hCAFE0001);
      flush();

      // Reset while a write is in its data phase: it must not commit.
      doWrite(32'h80, 3'd2, 32'h0);
      flush();
      doWrite(32'h80, 3'd2, 32'h12345678);
      HRESET = 1'b1;
      mSel = 1'b0;
      mTrans = 2'b00;
      @(posedge HCLK);
      #1;
      checkOutput("resetMid", pack(rdyOut, respOut, rdataOut, splitOut), pack(1'b1, 2'b00, 32'h0, 16'h0));
      HRESET = 1'b0;
      doRead(32'h80, 32'h0);
      flush();

      // Random mix of legal, illegal and idle beats over the initialised region.
      for (int i = 0; i < 150; i++) begin
        rKind  = $urandom_range(0, 19);
        rAddr  = $urandom_range(0, 255);
        rSize  = 3'($urandom_range(0, 2));
        rWrite = 1'($urandom_range(0, 1));
        rTrans = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10;
        rSel   = 1'b1;
        case (rKind)
          0: rTrans = 2'b00;
          1: rTrans = 2'b01;
          2: rSel = 1'b0;
          3: rAddr = rAddr | (32'h1000 << $urandom_range(0, 3));
          4: rSize = 3'($urandom_range(3, 7));
          5: rAddr = rAddr;
          default: rAddr = rAddr & ~((32'd1 << rSize) - 32'd1);
        endcase
        applyStimulus(rSel, rTrans, rWrite, rSize, rAddr, $urandom, 1'b0, 32'h0);
      end
      flush();
      checkOutput("queueDrained", 64'(expQ.size()), 64'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
